// File: rtl/counter_bank_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_bank_sequencer_if
//
// Requester-side bus of the counter bank sequencer: the snapshot request/ack
// handshake and the registered snapshot read port.
//
//   snapshot_req_i  requester -> sequencer  level request, held until ack
//   snapshot_ack_o  sequencer -> requester  one-cycle pulse, snapshot valid
//   rd_en_i         requester -> sequencer  read strobe
//   rd_addr_i       requester -> sequencer  counter index (6 bits)
//   rd_data_o       sequencer -> requester  registered read data
//   rd_valid_o      sequencer -> requester  one-cycle pulse qualifying rd_data_o
//
// master = requester, slave = sequencer.
// -----------------------------------------------------------------------------
interface counter_bank_sequencer_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 snapshot_req_i;
  logic                 snapshot_ack_o;
  logic                 rd_en_i;
  logic [5:0]           rd_addr_i;
  logic [BIT_WIDTH-1:0] rd_data_o;
  logic                 rd_valid_o;

  modport master (
    output snapshot_req_i, rd_en_i, rd_addr_i,
    input  snapshot_ack_o, rd_data_o, rd_valid_o
  );

  modport slave (
    input  snapshot_req_i, rd_en_i, rd_addr_i,
    output snapshot_ack_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/counter_bank_sequencer.sv
// -----------------------------------------------------------------------------
// counter_bank_sequencer
//
// Controller for a bank of K-modular-redundant event counters. Event pulses
// are forwarded as replicated countup strobes; a snapshot request runs
// LATCH (capture all counters) -> CLEAR (pulse reset_counter) -> DONE (ack).
// Events arriving while strobes are blocked are held in a 2-bit per-counter
// pending count and replayed later, so none are lost.
//
// Ports:
//   clk              clock
//   rst              asynchronous, active-high reset
//   event_i          [NUM_COUNTERS] one-cycle event pulses
//   counter_value_i  [NUM_COUNTERS][K_MMR][BIT_WIDTH] per-replica counter values
//   countup_o        [NUM_COUNTERS][K_MMR] registered countup strobes
//   reset_counter_o  [NUM_COUNTERS][K_MMR] registered clear strobes
//   mismatch_o       sticky replica-disagreement flag
//   bus              counter_bank_sequencer_if.slave (request/ack + read port)
//
// Configuration macro: COUNTER_BANK_SEQ_VOTE_EN
//   defined   : snapshot captures the bitwise majority of the replicas and
//               mismatch_o flags any replica that disagrees with the vote.
//   undefined : snapshot captures replica 0, mismatch_o is tied to 0.
// -----------------------------------------------------------------------------
module counter_bank_sequencer #(
  parameter int K_MMR        = 3,
  parameter int NUM_COUNTERS = 8,
  parameter int BIT_WIDTH    = 16
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NUM_COUNTERS-1:0]                            event_i,
  input  logic [NUM_COUNTERS-1:0][K_MMR-1:0][BIT_WIDTH-1:0]  counter_value_i,
  output logic [NUM_COUNTERS-1:0][K_MMR-1:0]                 countup_o,
  output logic [NUM_COUNTERS-1:0][K_MMR-1:0]                 reset_counter_o,
  output logic                                               mismatch_o,
  counter_bank_sequencer_if.slave                            bus
);

  localparam int AW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, CLEAR, DONE} state_t;

  state_t               state, state_next;
  logic [1:0]           pend      [NUM_COUNTERS];
  logic [1:0]           pend_next [NUM_COUNTERS];
  logic [2:0]           pend_sum  [NUM_COUNTERS];
  logic                 pend_busy;
  logic                 replay_en;
  logic [NUM_COUNTERS-1:0] countup_q, countup_next;
  logic                 reset_q;
  logic                 ack_q;
  logic [BIT_WIDTH-1:0] snap     [NUM_COUNTERS];
  logic [BIT_WIDTH-1:0] captured [NUM_COUNTERS];
  logic [AW-1:0]        rd_idx;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) is reserved for combinational blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    pend_busy = 1'b0;
    for (int n = 0; n < NUM_COUNTERS; n++)
      if (pend[n] != 2'd0) pend_busy = 1'b1;
  end

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.snapshot_req_i && !pend_busy) state_next = LATCH;
      LATCH:   state_next = CLEAR;
      CLEAR:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event forwarding / pending replay
  // ---------------------------------------------------------------------------
  // The strobe register holds what is visible in the cycle being entered, so
  // strobes are gated by state_next: LATCH and CLEAR block them. A fresh event
  // is added to the pending count and, when strobes are allowed, one unit is
  // issued. This covers both "pend drains when idle" and "an event takes the
  // drained slot". The all-zero entry guard caps the count at 2.
  assign replay_en = (state_next == IDLE) || (state_next == DONE);

  always_comb begin
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      pend_sum[n]     = {1'b0, pend[n]} + {2'b00, event_i[n]};
      countup_next[n] = 1'b0;
      pend_next[n]    = pend_sum[n][1:0];
      if (replay_en && (pend_sum[n] != 3'd0)) begin
        countup_next[n] = 1'b1;
        pend_next[n]    = 2'(pend_sum[n] - 3'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countup_q <= '0;
      reset_q   <= 1'b0;
      ack_q     <= 1'b0;
      for (int n = 0; n < NUM_COUNTERS; n++) pend[n] <= 2'd0;
    end else begin
      countup_q <= countup_next;
      reset_q   <= (state_next == CLEAR);
      ack_q     <= (state_next == DONE);
      for (int n = 0; n < NUM_COUNTERS; n++) pend[n] <= pend_next[n];
    end
  end

  for (genvar n = 0; n < NUM_COUNTERS; n++) begin : g_countup
    assign countup_o[n] = {K_MMR{countup_q[n]}};
  end
  assign reset_counter_o    = {(NUM_COUNTERS*K_MMR){reset_q}};
  assign bus.snapshot_ack_o = ack_q;

  // ---------------------------------------------------------------------------
  // Capture path (optional voter)
  // ---------------------------------------------------------------------------
`ifdef COUNTER_BANK_SEQ_VOTE_EN
  logic [NUM_COUNTERS-1:0] disagree;
  logic                    mismatch_q;

  function automatic logic [BIT_WIDTH-1:0] vote(
    input logic [K_MMR-1:0][BIT_WIDTH-1:0] r
  );
    logic [BIT_WIDTH-1:0] v;
    int ones;
    v = '0;
    for (int b = 0; b < BIT_WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < K_MMR; k++) ones += int'(r[k][b]);
      v[b] = (ones > K_MMR / 2);
    end
    return v;
  endfunction

  always_comb begin
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      captured[n] = vote(counter_value_i[n]);
      disagree[n] = 1'b0;
      for (int k = 0; k < K_MMR; k++)
        if (counter_value_i[n][k] != captured[n]) disagree[n] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              mismatch_q <= 1'b0;
    else if (state == LATCH && |disagree) mismatch_q <= 1'b1;
  end
  assign mismatch_o = mismatch_q;
`else
  always_comb begin
    for (int n = 0; n < NUM_COUNTERS; n++) captured[n] = counter_value_i[n][0];
  end
  assign mismatch_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Snapshot registers and read port
  // ---------------------------------------------------------------------------
  // NOTE: the snapshot array is explicitly reset because reads of a never-
  // captured counter must return 0, so it cannot be left to a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_COUNTERS; n++) snap[n] <= '0;
    end else if (state == LATCH) begin
      for (int n = 0; n < NUM_COUNTERS; n++) snap[n] <= captured[n];
    end
  end

  assign rd_idx = bus.rd_addr_i[AW-1:0];

  // A read at the LATCH edge still sees the old snapshot (pre-edge value).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid_o <= 1'b0;
      bus.rd_data_o  <= '0;
    end else begin
      bus.rd_valid_o <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        if (int'(bus.rd_addr_i) < NUM_COUNTERS) bus.rd_data_o <= snap[rd_idx];
        else                                    bus.rd_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_bank_sequencer
//
// Scoreboarded bench: the driver advances a behavioural model once per clock
// edge and queues the outputs it expects in the following cycle; a monitor on
// the falling edge compares whatever the DUT shows against the queue head.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_counter_bank_sequencer;

  localparam int K = 3;
  localparam int N = 8;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]                ev = '0;
  logic [N-1:0][K-1:0][W-1:0]  cv = '0;
  logic [N-1:0][K-1:0]         countup_o;
  logic [N-1:0][K-1:0]         reset_counter_o;
  logic                        mismatch_o;

  counter_bank_sequencer_if #(.BIT_WIDTH(W)) bus ();

  counter_bank_sequencer #(.K_MMR(K), .NUM_COUNTERS(N), .BIT_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .event_i         (ev),
    .counter_value_i (cv),
    .countup_o       (countup_o),
    .reset_counter_o (reset_counter_o),
    .mismatch_o      (mismatch_o),
    .bus             (bus)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   owed[n]  : events not yet turned into a strobe
  //   phase    : 0 normal, 1 latching, 2 clearing, 3 acknowledging
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int           cyc;
    logic [N-1:0] cu;
    logic         rc;
    logic         ack;
    logic         rv;
    logic [W-1:0] rd;
  } exp_t;

  exp_t         expq[$];
  int           owed [N];
  logic [W-1:0] snap_m [N];
  logic         mism_m = 1'b0;
  int           phase = 0;
  int           cyc = 0;
  logic         ack_now = 1'b0;

  function automatic logic [W-1:0] ref_capture(input int n);
    logic [W-1:0] v;
`ifdef COUNTER_BANK_SEQ_VOTE_EN
    int cnt;
    v = '0;
    for (int b = 0; b < W; b++) begin
      cnt = 0;
      for (int k = 0; k < K; k++) if (cv[n][k][b]) cnt++;
      v[b] = (2 * cnt > K);
    end
`else
    v = cv[n][0];
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      owed[n]   = 0;
      snap_m[n] = '0;
    end
    mism_m  = 1'b0;
    phase   = 0;
    ack_now = 1'b0;
    expq.delete();
  endtask

  // Called at a rising edge with the inputs the DUT just sampled.
  task automatic model_step();
    exp_t e;
    int   nxt;
    bit   all_clear;
    bit   allow;
    logic [W-1:0] v;
    e = '0;
    e.cyc = cyc;
    all_clear = 1'b1;
    for (int n = 0; n < N; n++) if (owed[n] != 0) all_clear = 1'b0;
    case (phase)
      0:       nxt = (bus.snapshot_req_i && all_clear) ? 1 : 0;
      1:       nxt = 2;
      2:       nxt = 3;
      default: nxt = 0;
    endcase
    if (bus.rd_en_i) begin
      e.rv = 1'b1;
      e.rd = (int'(bus.rd_addr_i) < N) ? snap_m[bus.rd_addr_i] : '0;
    end
    if (phase == 1) begin
      for (int n = 0; n < N; n++) begin
        v = ref_capture(n);
`ifdef COUNTER_BANK_SEQ_VOTE_EN
        for (int k = 0; k < K; k++) if (cv[n][k] != v) mism_m = 1'b1;
`endif
        snap_m[n] = v;
      end
    end
    allow = (nxt == 0) || (nxt == 3);
    for (int n = 0; n < N; n++) begin
      owed[n] += int'(ev[n]);
      if (allow && owed[n] > 0) begin
        e.cu[n] = 1'b1;
        owed[n]--;
      end
    end
    e.rc    = (nxt == 2);
    e.ack   = (nxt == 3);
    ack_now = e.ack;
    phase   = nxt;
    if (|e.cu || e.rc || e.ack || e.rv) expq.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  exp_t         m_e;
  logic [N-1:0] cu_obs;
  logic         rep_ok;
  logic         active;

  always @(negedge clk) begin
    if (!rst) begin
      rep_ok = 1'b1;
      for (int n = 0; n < N; n++) begin
        cu_obs[n] = countup_o[n][0];
        if (countup_o[n] != {K{countup_o[n][0]}}) rep_ok = 1'b0;
      end
      active = |countup_o || |reset_counter_o || bus.snapshot_ack_o || bus.rd_valid_o;
      if (active || (expq.size() > 0 && expq[0].cyc == cyc)) begin
        m_e = '0;
        m_e.cyc = cyc;
        if (expq.size() > 0 && expq[0].cyc == cyc) m_e = expq.pop_front();
        check("countup", 64'(cu_obs), 64'(m_e.cu));
        check("countup_replicas_equal", 64'(rep_ok), 64'd1);
        check("reset_counter", 64'(reset_counter_o),
              m_e.rc ? 64'((1 << (N * K)) - 1) : 64'd0);
        check("snapshot_ack", 64'(bus.snapshot_ack_o), 64'(m_e.ack));
        check("rd_valid", 64'(bus.rd_valid_o), 64'(m_e.rv));
        if (m_e.rv) check("rd_data", 64'(bus.rd_data_o), 64'(m_e.rd));
        check("mismatch", 64'(mismatch_o), 64'(mism_m));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    if (ack_now) bus.snapshot_req_i = 1'b0;  // requester drops after ack
  endtask

  task automatic pulse(input logic [N-1:0] e);
    ev = e;
    tick();
    ev = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read(input int addr);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = 6'(addr);
    tick();
    bus.rd_en_i   = 1'b0;
  endtask

  task automatic snapshot();
    bus.snapshot_req_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_now) break;
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_countup"},       64'(countup_o), 64'd0);
    check({tag, "_reset_counter"}, 64'(reset_counter_o), 64'd0);
    check({tag, "_ack"},           64'(bus.snapshot_ack_o), 64'd0);
    check({tag, "_rd_valid"},      64'(bus.rd_valid_o), 64'd0);
    check({tag, "_rd_data"},       64'(bus.rd_data_o), 64'd0);
    check({tag, "_mismatch"},      64'(mismatch_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.snapshot_req_i = 1'b0;
    bus.rd_en_i        = 1'b0;
    bus.rd_addr_i      = '0;
    model_reset();

    #17;
    check_all_zero("reset");
    #5 rst = 1'b0;

    // Forwarding: three back-to-back events on counter 3.
    idle(3);
    ev = 8'h08;
    idle(3);
    ev = '0;
    idle(3);

    // Snapshot of constant 0x0005, then read-back incl. out-of-range index.
    for (int n = 0; n < N; n++) for (int k = 0; k < K; k++) cv[n][k] = 16'h0005;
    snapshot();
    for (int a = 0; a < N; a++) read(a);
    read(9);

    // Request and read in the same cycle, then a read during LATCH.
    for (int n = 0; n < N; n++) for (int k = 0; k < K; k++) cv[n][k] = W'(16'h0100 + n);
    bus.snapshot_req_i = 1'b1;
    read(0);
    read(1);
    idle(3);
    read(1);

    // Events during LATCH and CLEAR are replayed in DONE and the cycle after.
    bus.snapshot_req_i = 1'b1;
    tick();
    pulse(8'h04);
    pulse(8'h04);
    idle(4);

    // Request gating: counter 1 kept pending by a continuous event stream.
    bus.snapshot_req_i = 1'b1;
    tick();
    ev = 8'h02;
    idle(3);
    bus.snapshot_req_i = 1'b1;
    idle(5);
    ev = '0;
    for (int i = 0; i < 20 && !ack_now; i++) tick();
    idle(3);

    // Vote: counter 4 replicas disagree in one bit.
    cv[4][0] = 16'h0010;
    cv[4][1] = 16'h0010;
    cv[4][2] = 16'h0011;
    snapshot();
    read(4);

    // Asynchronous reset in the middle of CLEAR.
    bus.snapshot_req_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus.snapshot_req_i = 1'b0;
    model_reset();
    #1;
    check_all_zero("midseq_reset");
    #6 rst = 1'b0;
    read(4);
    snapshot();
    read(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      ev = N'($urandom & $urandom & $urandom);
      bus.rd_en_i   = ($urandom_range(0, 2) == 0);
      bus.rd_addr_i = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'($urandom_range(0, 11));
      if ($urandom_range(0, 15) == 0) begin
        for (int n = 0; n < N; n++) begin
          logic [W-1:0] base;
          base = W'($urandom);
          for (int k = 0; k < K; k++) cv[n][k] = base;
          if ($urandom_range(0, 3) == 0) cv[n][$urandom_range(0, K - 1)] = W'($urandom);
        end
      end
      if (!bus.snapshot_req_i && phase == 0 && $urandom_range(0, 15) == 0)
        bus.snapshot_req_i = 1'b1;
      tick();
    end
    ev          = '0;
    bus.rd_en_i = 1'b0;
    for (int i = 0; i < 20 && (phase != 0 || bus.snapshot_req_i); i++) tick();
    idle(6);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
